branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-stage branch target buffer with 2-bit direction counters.
- Predicts direction and target for the fetch PC in the same cycle; the prediction travels down the pipe as prev_taken.
- Consumes the Execution stage's resolution bundle: target_3, instructionPC_3, is_branchInst_3, taken_3, prev_taken_3.
- Trains the table from that bundle, and raises the mispredict redirect that flushes stages 1-2.

Parameters:
- INDEX_BITS, 4, log2 of entry count; table depth = 2**INDEX_BITS.
- CNT_W, 32, width of the two performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- memory_stall  in  1  pipeline freeze; blocks all table and counter updates
- PC_1  in  32  current fetch PC (halfword aligned)
- pred_taken_1  out  1  prediction for PC_1
- pred_target_1  out  32  predicted target; valid when pred_taken_1=1
- is_branchInst_3  in  1  EX stage holds a JAL/JALR/BEQ/BNE
- branch_type_3  in  2  0=JAL 1=JALR 2=BEQ 3=BNE
- instructionPC_3  in  32  PC of the resolving instruction
- target_3  in  32  resolved next PC (taken target, or PC+2/+4 when not taken)
- taken_3  in  1  resolved direction
- prev_taken_3  in  1  prediction that was made for this instruction
- mispredict  out  1  flush stages 1-2 and redirect fetch
- redirect_pc  out  32  PC to fetch on mispredict
- branch_count  out  CNT_W  resolved branches
- mispredict_count  out  CNT_W  mispredicts

Behaviour:
- Reset (async, rst_n=0): all valid bits cleared; counters and targets set to 0; branch_count and mispredict_count set to 0.
- Outputs during reset: pred_taken_1=0, pred_target_1=0, mispredict=0, redirect_pc=target_3. Reset asserted mid-operation discards all training immediately.
- Entry fields: valid, tag = PC[31:INDEX_BITS+1], target[31:0], ctr[1:0]. Entry index = PC[INDEX_BITS:1]; bit 1 is included so RVC halfword PCs map separately.
- Lookup is combinational from registered table contents, zero latency.
  - hit = valid && tag match.
  - pred_taken_1 = hit && ctr[1].
  - pred_target_1 = hit ? entry.target : 0.
- Update enable: upd = is_branchInst_3 && !memory_stall. The EX bundle is held across a stall, so each branch trains exactly once, on the first unstalled cycle.
- Update rules, applied at the posedge when upd=1, for the entry at instructionPC_3:
  - JALR: never allocated. An existing hit is invalidated, since its target is data-dependent.
  - JAL: allocate or overwrite with valid=1, tag, target=target_3, ctr=2'b11.
  - BEQ/BNE hit: ctr saturating +1 if taken_3, -1 otherwise (3 stays 3, 0 stays 0). target <= target_3 only when taken_3=1.
  - BEQ/BNE miss and taken_3=1: allocate with ctr=2'b10 (weakly taken), replacing any conflicting entry.
  - BEQ/BNE miss and taken_3=0: no write.
- Lookup/update collision (PC_1 and instructionPC_3 map to the same index in the same cycle): lookup returns pre-update contents; no bypass.
- mispredict = upd && (prev_taken_3 != taken_3), combinational.
  - A predicted-taken branch that is actually taken is not a mispredict; a wrong predicted target is only possible for JALR, which is never predicted taken.
  - redirect_pc = target_3 always (EX already supplies PC+2/+4 for not-taken).
- branch_count increments when upd=1. mispredict_count increments when mispredict=1. Both saturate at all-ones and do not wrap.

Decomposition:
- Shared package, also used by Execution and decode:
  - branch-type constants JAL=0, JALR=1, BEQ=2, BNE=3;
  - counter encodings SNT=0, WNT=1, WT=2, ST=3;
  - the entry index/tag slice helper.
- One sub-module, sat_counter2: the 2-bit saturating up/down counter with enable, instantiated per entry.
- Table storage, lookup and update logic stay in branch_predictor.

Test Plan:
- Reset, PC_1=0x00000100 -> pred_taken_1=0, pred_target_1=0, both counters 0; pulse rst_n low mid-run after training -> same reset values, no hit on any trained PC.
- BEQ at 0x100, taken, target 0x140, prev_taken_3=0 -> mispredict=1, redirect_pc=0x140. Next cycle PC_1=0x100 -> pred_taken_1=1, pred_target_1=0x140.
- Same BEQ resolved not-taken twice with target_3=0x104 -> ctr 2->1->0, pred_taken_1=0. The first resolution (prev_taken_3=1) gives mispredict=1, redirect_pc=0x104.
- Branch resolves with memory_stall=1 for 3 cycles then 0 -> exactly one ctr update, branch_count +1, mispredict asserted only in the unstalled cycle.
- RVC PCs 0x102 and 0x100 trained with targets 0x200 and 0x300 -> separate entries, each predicts its own target. JALR at 0x180 resolved taken -> mispredict=1 every time, never predicted.
- Collision: JAL at 0x120 resolving while PC_1=0x120 -> pred_taken_1=0 that cycle, 1 the next. Preload mispredict_count to all-ones, then mispredict -> count stays all-ones.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// ----------------------------------------------------------------------------
// branch_predictor_pkg
// Definitions shared by the fetch-stage predictor, decode and the Execution
// stage: branch-type codes, 2-bit direction counter encodings, and the helpers
// that split a PC into its BTB index and tag.
// ----------------------------------------------------------------------------
package branch_predictor_pkg;

    // Branch type as carried down the pipe on branch_type_3
    typedef enum logic [1:0] {
        JAL  = 2'd0,
        JALR = 2'd1,
        BEQ  = 2'd2,
        BNE  = 2'd3
    } br_type_e;

    // Direction counter encodings; bit 1 set means predict taken
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    // Index = PC[index_bits:1]. Bit 1 is included so RVC halfword PCs get
    // their own entries. Callers size-cast the result to index_bits.
    function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                             input int unsigned index_bits);
        logic [31:0] mask;
        mask = (32'd1 << index_bits) - 32'd1;
        return (pc >> 1) & mask;
    endfunction

    // Tag = PC[31:index_bits+1]. Callers size-cast to 31-index_bits.
    function automatic logic [31:0] bp_tag(input logic [31:0] pc,
                                           input int unsigned index_bits);
        return pc >> (index_bits + 1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// ----------------------------------------------------------------------------
// sat_counter2
// 2-bit saturating up/down counter with enable and synchronous load.
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset (counter -> 0)
//   i_en       count one step this cycle
//   i_up       step direction: 1 = +1 (sticks at 3), 0 = -1 (sticks at 0)
//   i_load     overwrite the counter with i_load_val (wins over i_en)
//   i_load_val value to load
//   o_cnt      current counter value
// ----------------------------------------------------------------------------
module sat_counter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_up,
    input  logic       i_load,
    input  logic [1:0] i_load_val,
    output logic [1:0] o_cnt
);

    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_load) begin
            w_cnt_next = i_load_val;
        end else if (i_en) begin
            if (i_up && (r_cnt != 2'b11)) begin
                w_cnt_next = r_cnt + 2'b01;
            end else if (!i_up && (r_cnt != 2'b00)) begin
                w_cnt_next = r_cnt - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'b00;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
// Fetch-stage branch target buffer with per-entry 2-bit direction counters.
// Predicts direction/target for PC_1 combinationally, trains from the EX-stage
// resolution bundle and raises the mispredict redirect.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   memory_stall       pipeline freeze; blocks table and counter updates
//   PC_1               fetch PC
//   pred_taken_1       predicted direction for PC_1
//   pred_target_1      predicted target (0 on a miss)
//   is_branchInst_3    EX holds a JAL/JALR/BEQ/BNE
//   branch_type_3      branch type (see br_type_e)
//   instructionPC_3    PC of the resolving instruction
//   target_3           resolved next PC
//   taken_3            resolved direction
//   prev_taken_3       direction that was predicted for it
//   mispredict         flush stages 1-2 and redirect fetch
//   redirect_pc        fetch PC on mispredict
//   branch_count       saturating count of resolved branches
//   mispredict_count   saturating count of mispredicts
// ----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memory_stall,
    input  logic [31:0]      PC_1,
    output logic             pred_taken_1,
    output logic [31:0]      pred_target_1,
    input  logic             is_branchInst_3,
    input  logic [1:0]       branch_type_3,
    input  logic [31:0]      instructionPC_3,
    input  logic [31:0]      target_3,
    input  logic             taken_3,
    input  logic             prev_taken_3,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned DEPTH = 2 ** INDEX_BITS;
    localparam int unsigned TAG_W = 31 - INDEX_BITS;

    // Table storage
    logic [DEPTH-1:0] r_valid;
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic [1:0]       w_ctr    [DEPTH];

    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispredict_count;

    // ------------------------------------------------------------------
    // Lookup: reads registered contents only, so a same-cycle update to the
    // same index is seen one cycle later.
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic                  w_lk_hit;
    logic [1:0]            w_lk_ctr;

    assign w_lk_idx = INDEX_BITS'(bp_index(PC_1, INDEX_BITS));
    assign w_lk_tag = TAG_W'(bp_tag(PC_1, INDEX_BITS));
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_ctr = w_ctr[w_lk_idx];

    assign pred_taken_1  = w_lk_hit && ((w_lk_ctr == WT) || (w_lk_ctr == ST));
    assign pred_target_1 = w_lk_hit ? r_target[w_lk_idx] : 32'd0;

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_W-1:0]      w_upd_tag;
    logic                  w_upd;
    logic                  w_upd_hit;
    logic                  w_alloc;      // write valid/tag/target
    logic                  w_inval;      // clear valid
    logic                  w_tgt_wr;     // refresh target only
    logic                  w_ctr_step;   // step counter by taken_3
    logic                  w_ctr_load;   // load counter with w_load_val
    logic [1:0]            w_load_val;

    assign w_upd_idx = INDEX_BITS'(bp_index(instructionPC_3, INDEX_BITS));
    assign w_upd_tag = TAG_W'(bp_tag(instructionPC_3, INDEX_BITS));
    // EX holds its bundle across a stall, so gating here trains exactly once
    assign w_upd     = is_branchInst_3 && !memory_stall;
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    always_comb begin
        w_alloc    = 1'b0;
        w_inval    = 1'b0;
        w_tgt_wr   = 1'b0;
        w_ctr_step = 1'b0;
        w_ctr_load = 1'b0;
        w_load_val = ST;
        if (w_upd) begin
            unique case (br_type_e'(branch_type_3))
                // Target is data-dependent: never keep a JALR entry
                JALR: w_inval = w_upd_hit;
                JAL: begin
                    w_alloc    = 1'b1;
                    w_ctr_load = 1'b1;
                    w_load_val = ST;
                end
                BEQ, BNE: begin
                    if (w_upd_hit) begin
                        w_ctr_step = 1'b1;
                        w_tgt_wr   = taken_3;
                    end else if (taken_3) begin
                        w_alloc    = 1'b1;
                        w_ctr_load = 1'b1;
                        w_load_val = WT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= target_3;
            end
            if (w_inval) begin
                r_valid[w_upd_idx] <= 1'b0;
            end
            if (w_tgt_wr) begin
                r_target[w_upd_idx] <= target_3;
            end
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_ctr
        logic w_sel;
        assign w_sel = (w_upd_idx == INDEX_BITS'(g));

        sat_counter2 u_ctr (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_en       (w_ctr_step && w_sel),
            .i_up       (taken_3),
            .i_load     (w_ctr_load && w_sel),
            .i_load_val (w_load_val),
            .o_cnt      (w_ctr[g])
        );
    end

    // ------------------------------------------------------------------
    // Redirect and performance counters
    // ------------------------------------------------------------------
    // Gated by rst_n so no redirect escapes while the table is being cleared
    assign mispredict  = rst_n && w_upd && (prev_taken_3 != taken_3);
    assign redirect_pc = target_3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_upd && (r_branch_count != '1)) begin
                r_branch_count <= r_branch_count + CNT_W'(1);
            end
            if (mispredict && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
